hard_fir: RTL and testbench
===========================

Name: hard_fir

Overview:
- 64-tap single-shot dot-product filter with a post-scale stage, for the hardware-filtering path.
- A coefficient set plus one scaling factor is written serially over the shared input bus; then 64 samples are streamed in.
- Once the 64th sample is accepted, the block outputs sum(sample[i]*coeff[i]) * scale as a signed integer.
- Coefficients and scale are fixed point, with FRAC_BITS fractional bits; samples are integers.

Parameters:
- TAPS, 64, number of coefficients/samples per block.
- DATA_W, 32, width of the in/out buses.
- COEFF_W, 16, stored width of each coefficient and the scale: the signed low bits of in.
- SAMPLE_W, 16, stored width of each sample: the signed low bits of in.
- FRAC_BITS, 11, fractional bits in each coefficient and in the scale.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- coeff_valid  in  1  when high, in carries a coefficient/scale word.
- sample_valid  in  1  when high, in carries a sample word.
- in  in  DATA_W  shared signed write bus.
- out  out  DATA_W  signed filter result, registered.
- out_valid  out  1  one-cycle pulse when out updates.
- coeff_ready  out  1  high once all TAPS coefficients and the scale are loaded.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Clears coeff_count, sample_idx, the accumulator, out, out_valid and coeff_ready.
  - Clears all coefficient registers and the scale register.
- Coefficient load:
  - On each clk edge with coeff_valid=1 and coeff_count<TAPS, store in[COEFF_W-1:0] into coeff[coeff_count], then increment.
  - When coeff_count==TAPS, store the word into scale instead and set coeff_ready=1.
  - After that, coeff_valid is ignored until reset.
- Sample accumulate:
  - A sample is accepted only when sample_valid=1 and coeff_ready=1.
  - Samples arriving before coeff_ready are dropped, with no state change.
  - An accepted sample s gives acc <= acc + s*coeff[sample_idx] and sample_idx <= sample_idx+1.
  - The accumulator is signed, COEFF_W+SAMPLE_W+log2(TAPS) bits (38 by default).
- Completion, on the edge that accepts sample_idx==TAPS-1:
  - total = acc + s*coeff[TAPS-1].
  - out <= (total*scale + 2^(2*FRAC_BITS-1)) >>> (2*FRAC_BITS), i.e. round-half-up, arithmetic shift.
  - The result is sign-extended or truncated to DATA_W.
  - out_valid=1 for that one cycle.
  - acc and sample_idx clear to 0 on the same edge.
- Latency: out is visible right after the clock edge that accepts the last sample.
- out holds its value until the next completed block or reset.
- Further sample blocks reuse the same coefficients; no reload is needed.
- Simultaneous coeff_valid and sample_valid:
  - Before coeff_ready, the coefficient write wins and the sample is dropped.
  - After coeff_ready, the sample is accepted and the coefficient write is ignored.
- Reset mid-load or mid-block aborts everything; the next write is coeff[0].
- The accuracy target is within ±2 LSB of the ideal real-valued result.

Optional Feature:
- Macro HARD_FIR_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit) and parameter OVF_LIMIT (default 511).
  - ovf is registered with out: 1 when the rounded result > OVF_LIMIT or < -OVF_LIMIT, else 0.
  - ovf clears on reset.
- When undefined: no ovf port or logic, and out behaviour is identical.

Test Plan:
- Load 64 coeffs of 2048 (1.0) and scale 1024 (0.5), then samples all 1 -> out=32, out_valid pulses once, on the 64th sample edge.
- Coeffs all -2048 (in=32'hFFFFF800), scale 512 (0.25), samples all 2 -> out=-32.
- coeff[0]=1024 (0.5), others 0, scale 1024, sample[0]=3, others 0 -> exact 0.75, out=1 (rounding check).
- Pulse sample_valid 5 times before coeff load completes, then do a full load, scale 2048, and 64 samples -> dropped samples have no effect; out equals the dot product.
- Load 30 coeffs, assert reset, then do a full load with coeff[0]=2048 and scale 2048; sample[0]=-100 -> out=-100, coeff_ready low during reset.
- Random coeffs in ±2 (×2048), scale in ±0.5, samples in ±254, 100 iterations with reset each time -> |out-ideal| <= 2; with HARD_FIR_OVF_FLAG_EN, ovf=1 exactly when |result| > 511.

Source files
------------

// File: rtl/hard_fir_if.sv
// Write/result bus of the hard_fir block: coefficient/sample writes in, filtered result out.
// master drives coeff_valid, sample_valid and in; slave drives out, out_valid, coeff_ready (and ovf
// when HARD_FIR_OVF_FLAG_EN is defined). No backpressure: the writer only watches coeff_ready.
interface hard_fir_if #(
  parameter int DATA_W = 32
);
  logic              coeff_valid;
  logic              sample_valid;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              coeff_ready;
`ifdef HARD_FIR_OVF_FLAG_EN
  logic              ovf;

  modport master (output coeff_valid, sample_valid, in,
                  input  out, out_valid, coeff_ready, ovf);
  modport slave  (input  coeff_valid, sample_valid, in,
                  output out, out_valid, coeff_ready, ovf);
`else
  modport master (output coeff_valid, sample_valid, in,
                  input  out, out_valid, coeff_ready);
  modport slave  (input  coeff_valid, sample_valid, in,
                  output out, out_valid, coeff_ready);
`endif
endinterface

// File: rtl/hard_fir.sv
// 64-tap single-shot dot product with fixed-point post-scale.
// Latency: out/out_valid registered on the edge that accepts the last sample of a block.
// Backpressure: none; samples before coeff_ready are dropped, coeff writes after it are ignored.
// Ports: clk, reset (async active-low), bus (hard_fir_if.slave: coeff_valid, sample_valid, in,
// out, out_valid, coeff_ready). Optional macro HARD_FIR_OVF_FLAG_EN adds bus.ovf and OVF_LIMIT.
module hard_fir #(
  parameter int TAPS      = 64,
  parameter int DATA_W    = 32,
  parameter int COEFF_W   = 16,
  parameter int SAMPLE_W  = 16,
  parameter int FRAC_BITS = 11
`ifdef HARD_FIR_OVF_FLAG_EN
  , parameter int OVF_LIMIT = 511
`endif
) (
  input logic       clk,
  input logic       reset,
  hard_fir_if.slave bus
);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int PROD_W = COEFF_W + SAMPLE_W;
  localparam int ACC_W  = COEFF_W + SAMPLE_W + IDX_W;
  // one spare bit so the rounding add cannot wrap at full-scale products
  localparam int SCL_W  = ACC_W + COEFF_W + 1;
  localparam int SHIFT  = 2 * FRAC_BITS;

  localparam logic [CNT_W-1:0]        TAPS_C = CNT_W'(TAPS);
  localparam logic [IDX_W-1:0]        LAST_C = IDX_W'(TAPS - 1);
  localparam logic signed [SCL_W-1:0] RND_C  = SCL_W'(64'sd1 <<< (SHIFT - 1));

  logic signed [COEFF_W-1:0] coeff [TAPS];
  logic signed [COEFF_W-1:0] scale;
  logic [CNT_W-1:0]          coeff_count;
  logic [IDX_W-1:0]          sample_idx;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         out_q;
  logic                      out_valid_q;
  logic                      coeff_ready_q;

  logic signed [SAMPLE_W-1:0] sample;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    total;
  logic signed [SCL_W-1:0]    scaled;
  logic signed [SCL_W-1:0]    shifted;
  logic                       accept;
  logic                       last;

  // only the low bits of the write bus carry data
  wire unused_in_hi = &{1'b0, bus.in[DATA_W-1:COEFF_W]};

  always_comb begin
    sample  = bus.in[SAMPLE_W-1:0];
    prod    = sample * coeff[sample_idx];
    total   = acc + ACC_W'(prod);
    scaled  = SCL_W'(total) * SCL_W'(scale);
    // round half up, then arithmetic shift drops both sets of fractional bits
    shifted = (scaled + RND_C) >>> SHIFT;
    accept  = bus.sample_valid && coeff_ready_q;
    last    = (sample_idx == LAST_C);
  end

`ifdef HARD_FIR_OVF_FLAG_EN
  localparam logic signed [SCL_W-1:0] LIM_C = SCL_W'(OVF_LIMIT);
  logic ovf_q;
  // judged on the full-width rounded value, before any truncation to DATA_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (accept && last) begin
      ovf_q <= (shifted > LIM_C) || (shifted < -LIM_C);
    end
  end
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) coeff[i] <= '0;
      scale         <= '0;
      coeff_count   <= '0;
      sample_idx    <= '0;
      acc           <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      coeff_ready_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.coeff_valid && !coeff_ready_q) begin
        // the word after the last coefficient is the scale factor
        if (coeff_count == TAPS_C) begin
          scale         <= bus.in[COEFF_W-1:0];
          coeff_ready_q <= 1'b1;
        end else begin
          coeff[coeff_count[IDX_W-1:0]] <= bus.in[COEFF_W-1:0];
          coeff_count                   <= coeff_count + CNT_W'(1);
        end
      end else if (accept) begin
        if (last) begin
          out_q       <= DATA_W'(shifted);
          out_valid_q <= 1'b1;
          acc         <= '0;
          sample_idx  <= '0;
        end else begin
          acc        <= total;
          sample_idx <= sample_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.coeff_ready = coeff_ready_q;
endmodule

// File: tb/tb_hard_fir.sv
// Directed and randomised checks of hard_fir: reset state, load/ready timing, dot product
// with scaling and rounding, dropped early samples, write collisions, reset mid-load.
module tb_hard_fir;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hard_fir_if #(.DATA_W(32)) bus ();

  hard_fir #(
    .TAPS(64), .DATA_W(32), .COEFF_W(16), .SAMPLE_W(16), .FRAC_BITS(11)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  int coef_tab [64];
  int samp_tab [64];

  task automatic check(input string tag, input longint obs, input longint exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.coeff_valid  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.in           = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // inject: coefficient index at which sample_valid is also raised (-1 for none)
  task automatic do_load(input string tag, input int scl, input int inject);
    for (int i = 0; i < 64; i++) begin
      bus.coeff_valid  = 1'b1;
      bus.sample_valid = (i == inject);
      bus.in           = coef_tab[i];
      @(posedge clk);
      #1;
    end
    bus.sample_valid = 1'b0;
    check({tag, "_ready_before_scale"}, bus.coeff_ready, 0);
    bus.in = scl;
    @(posedge clk);
    #1;
    idle_bus();
    check({tag, "_ready_after_scale"}, bus.coeff_ready, 1);
  endtask

  // inject: sample index at which coeff_valid is also raised (-1 for none)
  task automatic do_block(input string tag, input longint exp, input int inject);
    int early;
    early = 0;
    for (int i = 0; i < 64; i++) begin
      bus.sample_valid = 1'b1;
      bus.coeff_valid  = (i == inject);
      bus.in           = samp_tab[i];
      @(posedge clk);
      #1;
      if (i < 63 && bus.out_valid) early++;
    end
    idle_bus();
    check({tag, "_early_valid"}, early, 0);
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, longint'($signed(bus.out)), exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_hold"}, longint'($signed(bus.out)), exp);
  endtask

  initial begin
    longint dot, prodl, rnd;
    int scl;
    real diff;

    // reset state
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", longint'($signed(bus.out)), 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_coeff_ready", bus.coeff_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // coeffs 1.0, scale 0.5, samples 1 -> 64*0.5 = 32
    for (int i = 0; i < 64; i++) begin coef_tab[i] = 2048; samp_tab[i] = 1; end
    do_load("unity", 1024, -1);
    do_block("unity", 32, -1);
    // second block reuses coefficients: samples 3 -> 96
    for (int i = 0; i < 64; i++) samp_tab[i] = 3;
    do_block("reuse", 96, -1);

    // coeffs -1.0, scale 0.25, samples 2 -> -32
    do_reset();
    for (int i = 0; i < 64; i++) begin coef_tab[i] = -2048; samp_tab[i] = 2; end
    do_load("neg", 512, -1);
    do_block("neg", -32, -1);

    // 0.5 * 3 * 0.5 = 0.75 rounds to 1
    do_reset();
    for (int i = 0; i < 64; i++) begin coef_tab[i] = 0; samp_tab[i] = 0; end
    coef_tab[0] = 1024;
    samp_tab[0] = 3;
    do_load("round", 1024, -1);
    do_block("round", 1, -1);

    // early samples dropped, sample during load dropped, coeff during block ignored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.sample_valid = 1'b1;
      bus.in           = 1000;
      @(posedge clk);
      #1;
    end
    idle_bus();
    for (int i = 0; i < 64; i++) begin coef_tab[i] = 2048; samp_tab[i] = i; end
    do_load("drop", 2048, 10);
    do_block("drop", 2016, 5);

    // reset in the middle of a load
    do_reset();
    for (int i = 0; i < 30; i++) begin
      bus.coeff_valid = 1'b1;
      bus.in          = 7;
      @(posedge clk);
      #1;
    end
    idle_bus();
    reset = 1'b0;
    #2;
    check("midrst_ready", bus.coeff_ready, 0);
    check("midrst_out", longint'($signed(bus.out)), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin coef_tab[i] = 0; samp_tab[i] = 5; end
    coef_tab[0] = 2048;
    samp_tab[0] = -100;
    do_load("midrst", 2048, -1);
    do_block("midrst", -100, -1);

    // randomised blocks against the real-valued ideal
    for (int it = 0; it < 100; it++) begin
      do_reset();
      dot = 0;
      for (int i = 0; i < 64; i++) begin
        coef_tab[i] = int'($urandom_range(8192, 0)) - 4096;
        samp_tab[i] = int'($urandom_range(508, 0)) - 254;
        dot += longint'(coef_tab[i]) * longint'(samp_tab[i]);
      end
      scl   = int'($urandom_range(2048, 0)) - 1024;
      prodl = dot * longint'(scl);
      rnd   = (prodl + 64'sd2097152) >>> 22;
      do_load("rand", scl, -1);
      do_block("rand", rnd, -1);
      diff = real'($signed(bus.out)) - real'(prodl) / 4194304.0;
      check("rand_tol", (diff <= 2.0 && diff >= -2.0), 1);
`ifdef HARD_FIR_OVF_FLAG_EN
      check("rand_ovf", bus.ovf, (rnd > 511 || rnd < -511));
`endif
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
